// File: rtl/video_fetch_sched.sv
// Video fetch scheduler: arbitrates bitmap line bursts against sprite bursts
// and drives a single-outstanding-burst memory request port.
//
// Handshake: mem_req rises with mem_addr/mem_src valid and holds all three
// stable until the cycle mem_ack is sampled high; mem_ack outside a request
// has no effect. After every accepted burst mem_req is low for one cycle.
module video_fetch_sched #(
  parameter int ADDR_W      = 24,
  parameter int NBURST      = 20,
  parameter int BURST_BYTES = 128,
  parameter int LINE_STRIDE = 2560,
  parameter int VFIRST      = 27,
  parameter int DISP_LINES  = 768,
  parameter int SPR_EVERY   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              eol,
  input  logic              eof,
  input  logic [11:0]       vCtr,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic              spr_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_src,
  input  logic              mem_ack,
  output logic              underrun,
  output logic [1:0]        dbg_state
);

  localparam int BL_W = $clog2(NBURST + 1);
  localparam int GC_W = $clog2(SPR_EVERY + 1);
  localparam logic [BL_W-1:0]   BL_FULL   = BL_W'(NBURST);
  localparam logic [GC_W-1:0]   GC_MAX    = GC_W'(SPR_EVERY);
  localparam logic [ADDR_W-1:0] BURST_INC = ADDR_W'(BURST_BYTES);
  localparam logic [ADDR_W-1:0] LINE_INC  = ADDR_W'(LINE_STRIDE);

  typedef enum logic [1:0] {IDLE = 2'd0, BMP = 2'd1, SPR = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [BL_W-1:0]   bursts_left_q, bl_after;
  logic [GC_W-1:0]   gcnt_q;
  logic [ADDR_W-1:0] line_ptr_q, burst_addr_q, ptr_src;
  logic              stale_q;   // in-flight bitmap burst belongs to a superseded line
  logic              bmp_done, spr_done, arm, spr_turn, in_win;
  int                vctr_i;

  assign dbg_state = state_q;
  assign vctr_i    = int'(vCtr);
  assign in_win    = (vctr_i >= VFIRST - 1) && (vctr_i <= VFIRST + DISP_LINES - 2);

  // Burst completion, line arming and arbitration decisions
  always_comb begin
    bmp_done = (state_q == BMP) && mem_ack;
    spr_done = (state_q == SPR) && mem_ack;
    arm      = eol && enable && in_win;
    ptr_src  = eof ? base_addr : line_ptr_q;
    spr_turn = spr_req && (gcnt_q >= GC_MAX);
    bl_after = bursts_left_q;
    if (bmp_done && !stale_q && (bursts_left_q != '0))
      bl_after = bursts_left_q - BL_W'(1);
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // No new grant on an eol cycle: the line bookkeeping is being replaced.
        if (enable && !eol) begin
          if ((bursts_left_q != '0) && !spr_turn) state_d = BMP;
          else if (spr_req)                        state_d = SPR;
        end
      end
      BMP, SPR: if (mem_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State, registered outputs and line/burst bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_src       <= 1'b0;
      spr_ack       <= 1'b0;
      underrun      <= 1'b0;
      bursts_left_q <= '0;
      gcnt_q        <= '0;
      line_ptr_q    <= '0;
      burst_addr_q  <= '0;
      stale_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_req  <= (state_d != IDLE);
      spr_ack  <= spr_done;
      underrun <= eol && (bl_after != '0);

      if ((state_q == IDLE) && (state_d == BMP)) begin
        mem_addr <= burst_addr_q;
        mem_src  <= 1'b0;
      end else if ((state_q == IDLE) && (state_d == SPR)) begin
        mem_addr <= spr_addr;
        mem_src  <= 1'b1;
      end

      if (bmp_done) begin
        if (gcnt_q < GC_MAX) gcnt_q <= gcnt_q + GC_W'(1);
      end else if (spr_done) begin
        gcnt_q <= '0;
      end

      if (eof) line_ptr_q <= base_addr;

      if (eol) begin
        stale_q <= (state_q == BMP) && !mem_ack;
        if (arm) begin
          bursts_left_q <= BL_FULL;
          burst_addr_q  <= ptr_src;
          line_ptr_q    <= ptr_src + LINE_INC;
        end else begin
          bursts_left_q <= '0;
        end
      end else if (bmp_done) begin
        if (stale_q) begin
          stale_q <= 1'b0;
        end else if (bursts_left_q != '0) begin
          bursts_left_q <= bursts_left_q - BL_W'(1);
          burst_addr_q  <= burst_addr_q + BURST_INC;
        end
      end

      if (!enable) bursts_left_q <= '0;
    end
  end

endmodule

// File: tb/tb_video_fetch_sched.sv
// Bench for video_fetch_sched: vector table of line-arming cases, hand-written
// multi-cycle sequences, and randomized lines against a line-pointer model.
module tb_video_fetch_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1, eol = 1'b0, eof = 1'b0, spr_req = 1'b0;
  logic        mem_ack = 1'b0;
  logic [11:0] vctr = '0;
  logic [23:0] base_addr = '0, spr_addr = '0;
  logic        spr_ack, mem_req, mem_src, underrun;
  logic [23:0] mem_addr;
  logic [1:0]  dbg_state;

  int n_checks = 0, n_fail = 0, n_spr_ack = 0;
  logic [24:0] obs_q[$];
  logic [24:0] exp_q[$];
  logic ack_en = 1'b1;
  int lat_max = 0, lat_cnt = 0;
  logic p_req = 1'b0, p_ack = 1'b0;
  logic [24:0] p_word = '0;

  typedef struct {
    logic [11:0] vctr;
    logic        en;
    logic [23:0] base;
    int          exp_n;
    logic [23:0] exp_first;
  } vec_t;
  vec_t vecs[6];

  video_fetch_sched dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .eol(eol), .eof(eof),
    .vCtr(vctr), .base_addr(base_addr), .spr_req(spr_req), .spr_addr(spr_addr),
    .spr_ack(spr_ack), .mem_req(mem_req), .mem_addr(mem_addr), .mem_src(mem_src),
    .mem_ack(mem_ack), .underrun(underrun), .dbg_state(dbg_state)
  );

  // Clock / reset-time watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Memory responder: ack after a random 0..lat_max wait, one-cycle pulse
  always @(posedge clk) begin
    #1;
    if (mem_ack) mem_ack = 1'b0;
    else if (mem_req && ack_en) begin
      if (lat_cnt == 0) begin
        mem_ack = 1'b1;
        lat_cnt = int'($urandom_range(lat_max, 0));
      end else lat_cnt--;
    end
  end

  // Monitor: request hold, one idle cycle after ack, burst log, spr_ack count
  always @(negedge clk) begin
    if (!rst_n) begin
      p_req = 1'b0;
      p_ack = 1'b0;
    end else begin
      if (p_req && !p_ack) begin
        chk("req_hold", 32'(mem_req), 32'd1);
        chk("req_stable", 32'({mem_src, mem_addr}), 32'(p_word));
      end
      if (p_req && p_ack) chk("idle_after_ack", 32'(mem_req), 32'd0);
      if (mem_req && mem_ack) obs_q.push_back({mem_src, mem_addr});
      if (spr_ack) n_spr_ack++;
      p_req  = mem_req;
      p_ack  = mem_ack;
      p_word = {mem_src, mem_addr};
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_eof(input logic [23:0] b);
    base_addr = b;
    eof = 1'b1;
    tick();
    eof = 1'b0;
  endtask

  task automatic do_eol(input logic [11:0] v);
    vctr = v;
    eol = 1'b1;
    tick();
    eol = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    tick();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic exp_line(input logic [23:0] first, input int n);
    logic [23:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, a});
      a = a + 24'd128;
    end
  endtask

  task automatic cmp_stream(input string nm);
    int n;
    chk({nm, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", nm, i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int k, mode;
    logic [23:0] mptr, nb;
    logic [11:0] v;

    vecs[0] = '{12'd26,  1'b1, 24'h100000, 20, 24'h100000};
    vecs[1] = '{12'd25,  1'b1, 24'h110000, 0,  24'h000000};
    vecs[2] = '{12'd793, 1'b1, 24'h200000, 20, 24'h200000};
    vecs[3] = '{12'd794, 1'b1, 24'h210000, 0,  24'h000000};
    vecs[4] = '{12'd100, 1'b0, 24'h220000, 0,  24'h000000};
    vecs[5] = '{12'd400, 1'b1, 24'hFFFF00, 20, 24'hFFFF00};

    // Reset values
    run(3);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_src", 32'(mem_src), 0);
    chk("rst_spr_ack", 32'(spr_ack), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    run(5);
    chk("rst_no_req", 32'(obs_q.size()), 0);

    // Line-arming vector table
    for (int i = 0; i < 6; i++) begin
      enable = vecs[i].en;
      do_eof(vecs[i].base);
      do_eol(vecs[i].vctr);
      run(60);
      exp_line(vecs[i].exp_first, vecs[i].exp_n);
      cmp_stream($sformatf("vec%0d", i));
      enable = 1'b1;
    end

    // Consecutive lines advance by the stride; line past the window fetches nothing
    do_eof(24'h100000);
    do_eol(12'd26);
    run(50);
    do_eol(12'd27);
    run(50);
    do_eol(12'd794);
    run(30);
    exp_line(24'h100000, 20);
    exp_line(24'h100A00, 20);
    cmp_stream("line_seq");

    // Sprite interleave: four bitmap grants then one sprite
    do_reset();
    n_spr_ack = 0;
    spr_addr = 24'h002000;
    do_eof(24'h700000);
    do_eol(12'd30);
    spr_req = 1'b1;
    k = 0;
    while (obs_q.size() < 25 && k < 400) begin
      tick();
      k++;
    end
    chk("spr_budget", 32'(k < 400), 1);
    spr_req = 1'b0;
    run(20);
    for (int g = 0; g < 5; g++) begin
      exp_line(24'h700000 + 24'(g * 512), 4);
      exp_q.push_back({1'b1, 24'h002000});
    end
    chk("spr_ack_count", 32'(n_spr_ack), 5);
    cmp_stream("spr_mix");

    // Underrun: eol while the line is stalled
    do_reset();
    ack_en = 1'b0;
    do_eof(24'h600000);
    do_eol(12'd100);
    run(3);
    chk("ur_req", 32'(mem_req), 1);
    chk("ur_addr", 32'(mem_addr), 32'h600000);
    chk("ur_before", 32'(underrun), 0);
    do_eol(12'd101);
    chk("ur_pulse", 32'(underrun), 1);
    tick();
    chk("ur_pulse_end", 32'(underrun), 0);
    ack_en = 1'b1;
    run(60);
    exp_q.push_back({1'b0, 24'h600000});
    exp_line(24'h600A00, 20);
    cmp_stream("ur_stream");

    // Enable dropped mid-line: in-flight burst completes, nothing afterwards
    do_reset();
    do_eof(24'h500000);
    do_eol(12'd200);
    k = 0;
    while (obs_q.size() < 3 && k < 100) begin
      tick();
      k++;
    end
    chk("en_budget", 32'(k < 100), 1);
    tick();
    chk("en_inflight", 32'(mem_req), 1);
    enable = 1'b0;
    run(40);
    exp_line(24'h500000, 4);
    cmp_stream("en_drop");
    do_eol(12'd300);
    run(30);
    enable = 1'b1;
    run(30);
    cmp_stream("en_off_eol");

    // Asynchronous reset while a request is outstanding
    ack_en = 1'b0;
    do_eof(24'h300000);
    do_eol(12'd50);
    run(3);
    chk("ar_req_before", 32'(mem_req), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_req_async", 32'(mem_req), 0);
    chk("ar_addr_async", 32'(mem_addr), 0);
    chk("ar_state_async", 32'(dbg_state), 0);
    tick();
    rst_n = 1'b1;
    ack_en = 1'b1;
    obs_q.delete();
    run(30);
    cmp_stream("ar_quiet");
    do_eof(24'h400000);
    do_eol(12'd60);
    run(60);
    exp_line(24'h400000, 20);
    cmp_stream("ar_resume");

    // Randomized lines with random ack latency against the line-pointer model
    lat_max = 3;
    do_reset();
    nb = 24'($urandom);
    do_eof(nb);
    mptr = nb;
    for (int it = 0; it < 20; it++) begin
      nb = 24'($urandom);
      base_addr = nb;
      mode = int'($urandom_range(3, 0));
      v = 12'($urandom_range(810, 15));
      if (mode == 0) begin
        do_eof(nb);
        mptr = nb;
        do_eol(v);
      end else if (mode == 1) begin
        vctr = v;
        eof = 1'b1;
        eol = 1'b1;
        tick();
        eof = 1'b0;
        eol = 1'b0;
        mptr = nb;
      end else begin
        do_eol(v);
      end
      if (v >= 12'd26 && v <= 12'd793) begin
        exp_line(mptr, 20);
        mptr = mptr + 24'd2560;
      end
      run(150);
    end
    cmp_stream("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_fetch_sched.md
VIDEO_FETCH_SCHED -- requirements
Module: video_fetch_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, memory byte-address width.
REQ-002 SHALL have parameter NBURST, default 20, bitmap bursts per display line.
REQ-003 SHALL have parameter BURST_BYTES, default 128, byte-address increment per burst.
REQ-004 SHALL have parameter LINE_STRIDE, default 2560, byte-address increment per line.
REQ-005 SHALL have parameter VFIRST, default 27, first displayed scan line number.
REQ-006 SHALL have parameter DISP_LINES, default 768, number of displayed lines.
REQ-007 SHALL have parameter SPR_EVERY, default 4, bitmap grants after which a pending sprite request wins.
REQ-008 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have ports: enable in 1, fetch enable; eol in 1, one-cycle end-of-line pulse from the sync generator; eof in 1, one-cycle end-of-frame pulse; vCtr in 12, current scan line; base_addr in ADDR_W, frame base.
REQ-011 SHALL have ports: spr_req in 1, level sprite request; spr_addr in ADDR_W, stable while spr_req high; spr_ack out 1, one-cycle grant-complete pulse.
REQ-012 SHALL have ports: mem_req out 1; mem_addr out ADDR_W; mem_src out 1 (0 bitmap, 1 sprite); mem_ack in 1, one-cycle burst acceptance; underrun out 1, one-cycle pulse.

Function
REQ-013 SHALL implement states IDLE, BMP, SPR; BMP/SPR hold mem_req high with mem_addr and mem_src stable until mem_ack.
REQ-014 SHALL treat mem_ack as completing a burst only while mem_req is high; mem_ack in IDLE is ignored.
REQ-015 SHALL return to IDLE for exactly one cycle after each mem_ack (mem_req low), then re-arbitrate.
REQ-016 SHALL load line pointer = base_addr on eof; base_addr is not sampled at any other time.
REQ-017 SHALL, on eol with enable high and VFIRST-1 <= vCtr <= VFIRST+DISP_LINES-2, arm a line fetch: bursts_left = NBURST, burst address = line pointer, then line pointer += LINE_STRIDE.
REQ-018 SHALL, on eol while bursts_left != 0, pulse underrun the next cycle, discard the remaining bursts, and arm the new line per REQ-017; a burst already requested completes normally but decrements the new line's count only if it is a new-line burst.
REQ-019 SHALL, when eol and eof coincide, apply the eof reload first so an armed line uses base_addr.
REQ-020 SHALL arbitrate from IDLE: if bursts_left != 0 and not (spr_req and grant count >= SPR_EVERY) go BMP; else if spr_req go SPR; else stay IDLE.
REQ-021 SHALL increment the bitmap grant count on each bitmap mem_ack, saturating at SPR_EVERY; clear it on each sprite mem_ack.
REQ-022 SHALL, on bitmap mem_ack, decrement bursts_left and add BURST_BYTES to the burst address; addresses wrap modulo 2^ADDR_W.
REQ-023 SHALL, on sprite mem_ack, pulse spr_ack in the same cycle as mem_ack is sampled (registered, visible next cycle) and drive mem_addr = spr_addr captured at SPR entry.
REQ-024 SHALL, with enable low, arm no new lines and start no new bursts; a burst in BMP/SPR completes; bursts_left is cleared.
REQ-025 SHALL drive all outputs from registers.

Reset
REQ-026 SHALL, while rst_n low, asynchronously force state IDLE, mem_req 0, mem_addr 0, mem_src 0, spr_ack 0, underrun 0, bursts_left 0, grant count 0, line pointer 0.
REQ-027 SHALL abandon any in-flight burst on reset without waiting for mem_ack.

Verification
REQ-028 base_addr=0x100000, eof, eol at vCtr=26, mem_ack one cycle after each mem_req -> 20 bitmap bursts at 0x100000..0x100980 step 0x80, one idle cycle between each.
REQ-029 Next eol at vCtr=27 -> bursts start at 0x100A00; eol at vCtr=794 -> no fetch.
REQ-030 spr_req held, spr_addr=0x2000, bitmap line armed -> order: 4 bitmap, 1 sprite (mem_src=1, addr 0x2000, spr_ack pulse), 4 bitmap, ...
REQ-031 mem_ack withheld, eol arrives with 20 bursts pending -> underrun pulse exactly one cycle; new line armed at next stride address.
REQ-032 rst_n low mid-burst with mem_req high -> mem_req 0 immediately, no clock needed; after release, no requests until eof then qualifying eol.
REQ-033 enable low during line -> current burst completes, no further mem_req; eol with enable low arms nothing.
